// File: rtl/uart9_tx_arbiter_pkg.sv
// Shared types and constants for the 9-bit UART transmit arbiter.
package uart9_pkg;

  localparam int unsigned WORD_W = 9;
  localparam int unsigned ID_W   = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    DONE  = 3'd3,
    GAP   = 3'd4
  } state_e;

endpackage

// File: rtl/uart9_tx_arbiter_if.sv
// Requester and transmitter signals of the arbiter; master = arbiter side.
interface uart9_tx_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  import uart9_pkg::*;

  logic [N_REQ-1:0]        req;
  logic [WORD_W*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]        ack;
  logic                    ld_tx_data;
  logic [WORD_W-1:0]       tx_data;
  logic                    tx_empty;

  modport master (
    input  req, req_data, tx_empty,
    output ack, ld_tx_data, tx_data
  );

  modport slave (
    output req, req_data, tx_empty,
    input  ack, ld_tx_data, tx_data
  );

endinterface

// File: rtl/uart9_tx_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request after index 'last'.
module uart9_rr_pick
  import uart9_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last,
  output logic [ID_W-1:0]  grant,
  output logic             valid
);

  int unsigned idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = (32'(last) + k) % N_REQ;
      for (int unsigned j = 0; j < N_REQ; j++) begin
        if (!valid && (j == idx) && req[j]) begin
          valid = 1'b1;
          grant = ID_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/uart9_tx_arbiter.sv
// Round-robin arbiter feeding 9-bit words to a UART transmitter.
// Optional watchdog on START/DONE waits: define UART9_TX_ARB_TIMEOUT_EN.
module uart9_tx_arbiter
  import uart9_pkg::*;
#(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             txclk,
  input  logic             reset,
  input  logic             en,
  input  logic             err_clr,
  output logic             busy,
  output logic [ID_W-1:0]  cur_id,
  output logic             err_timeout,
  output logic             tx_enable,
  uart9_tx_arbiter_if.master bus
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   cur_id_q, cur_id_d;
  logic [WORD_W-1:0] tx_data_q, tx_data_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [ID_W-1:0]   pick_id;
  logic              pick_valid;
  logic [WORD_W-1:0] pick_word;

  uart9_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (bus.req),
    .last  (cur_id_q),
    .grant (pick_id),
    .valid (pick_valid)
  );

  always_comb begin
    pick_word = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (32'(pick_id) == i) pick_word = bus.req_data[WORD_W*i +: WORD_W];
    end
  end

`ifdef UART9_TX_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_q, err_d;
  logic            waiting;

  always_comb begin
    waiting = ((state_q == START) && bus.tx_empty) || ((state_q == DONE) && !bus.tx_empty);
  end
`else
  logic unused_cfg;
  always_comb unused_cfg = err_clr ^ (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    state_d   = state_q;
    cur_id_d  = cur_id_q;
    tx_data_d = tx_data_q;
    gap_cnt_d = gap_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (en && pick_valid) begin
          state_d   = LOAD;
          cur_id_d  = pick_id;
          tx_data_d = pick_word;
        end
      end
      LOAD:  state_d = START;
      START: if (!bus.tx_empty) state_d = DONE;
      DONE: begin
        if (bus.tx_empty) begin
          state_d   = (GAP_CYCLES == 0) ? IDLE : GAP;
          gap_cnt_d = '0;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
          state_d   = IDLE;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef UART9_TX_ARB_TIMEOUT_EN
    // Watchdog overrides the wait states; a new timeout beats err_clr.
    err_d    = err_q & ~err_clr;
    to_cnt_d = '0;
    if (waiting) begin
      if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
        state_d = IDLE;
        err_d   = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end
`endif
  end

  always_comb begin
    busy           = (state_q != IDLE);
    bus.ld_tx_data = (state_q == LOAD);
    bus.tx_data    = tx_data_q;
    cur_id         = cur_id_q;
    tx_enable      = en;
    bus.ack        = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      bus.ack[i] = (state_q == LOAD) && (32'(cur_id_q) == i);
    end
`ifdef UART9_TX_ARB_TIMEOUT_EN
    err_timeout = err_q;
`else
    err_timeout = 1'b0;
`endif
  end

  always_ff @(posedge txclk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cur_id_q  <= ID_W'(N_REQ - 1);
      tx_data_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cur_id_q  <= cur_id_d;
      tx_data_q <= tx_data_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

`ifdef UART9_TX_ARB_TIMEOUT_EN
  always_ff @(posedge txclk or negedge reset) begin
    if (!reset) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end
`endif

endmodule

// File: tb/tb_uart9_tx_arbiter.sv
// Scoreboard bench for uart9_tx_arbiter with a simple transmitter model.
module tb_uart9_tx_arbiter;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned GAP   = 2;
  localparam int unsigned TMO   = 255;

  logic       txclk   = 1'b0;
  logic       reset   = 1'b0;
  logic       en      = 1'b0;
  logic       err_clr = 1'b0;
  logic       busy;
  logic [2:0] cur_id;
  logic       err_timeout;
  logic       tx_enable;

  uart9_tx_arbiter_if #(.N_REQ(N_REQ)) bus ();

  uart9_tx_arbiter #(
    .N_REQ          (N_REQ),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .txclk       (txclk),
    .reset       (reset),
    .en          (en),
    .err_clr     (err_clr),
    .busy        (busy),
    .cur_id      (cur_id),
    .err_timeout (err_timeout),
    .tx_enable   (tx_enable),
    .bus         (bus.master)
  );

  typedef struct packed {
    logic [2:0] id;
    logic [8:0] data;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  logic [3:0] exp_ack;

  int n_cmp     = 0;
  int n_err     = 0;
  int cyc       = 0;
  int n_ld      = 0;
  int ld_cyc    = 0;
  int last_rise = -1;
  int hold      = 0;
  int tx_state  = 0;
  int tx_hold   = 3;
  int req_cyc   = 0;
  int n0        = 0;
  bit tx_stuck  = 1'b0;
  bit gap_chk   = 1'b0;
  bit prev_ld   = 1'b0;

  always #5 txclk = ~txclk;
  always @(posedge txclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [2:0] id, input logic [8:0] data);
    exp_t e;
    e.id   = id;
    e.data = data;
    sb_q.push_back(e);
  endtask

  task automatic wait_ld(input int target, input string tag);
    int k = 0;
    while (n_ld < target && k < 300) begin
      @(negedge txclk);
      k++;
    end
    if (n_ld < target) check(tag, 32'(n_ld), 32'(target));
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 300) begin
      @(negedge txclk);
      k++;
    end
    check(tag, busy, 1'b0);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_ld"}, bus.ld_tx_data, 1'b0);
    check({tag, "_ack"}, bus.ack, 4'h0);
    check({tag, "_txdata"}, bus.tx_data, 9'h000);
    check({tag, "_curid"}, cur_id, 3'(N_REQ - 1));
    check({tag, "_err"}, err_timeout, 1'b0);
  endtask

  // Transmitter model plus output monitor: tx_empty falls the cycle after
  // LOAD, stays low for tx_hold cycles, then rises.
  always @(negedge txclk) begin
    if (!reset) begin
      tx_state     = 0;
      bus.tx_empty = 1'b1;
      prev_ld      = 1'b0;
    end else begin
      case (tx_state)
        1: if (!tx_stuck) begin
             bus.tx_empty = 1'b0;
             hold         = tx_hold;
             tx_state     = 2;
           end
        2: if (hold <= 1) begin
             bus.tx_empty = 1'b1;
             last_rise    = cyc;
             tx_state     = 0;
           end else begin
             hold--;
           end
        default: ;
      endcase
      if (bus.ld_tx_data) begin
        check("ld_pulse", prev_ld, 1'b0);
        ld_cyc = cyc;
        n_ld++;
        if (sb_q.size() == 0) begin
          check("ld_unexpected", 1'b1, 1'b0);
        end else begin
          mon_e   = sb_q.pop_front();
          exp_ack = 4'(1) << mon_e.id;
          check("tx_data", bus.tx_data, mon_e.data);
          check("cur_id", cur_id, mon_e.id);
          check("ack", bus.ack, exp_ack);
        end
        // GAP cycles plus the IDLE evaluation cycle after tx_empty rises
        if (gap_chk && last_rise >= 0) check("gap", 32'(cyc - last_rise), GAP + 2);
        tx_state = 1;
      end else begin
        check("ack_idle", bus.ack, 4'h0);
      end
      prev_ld = bus.ld_tx_data;
    end
  end

  initial begin
    bus.req      = '0;
    bus.req_data = '0;
    #12;
    reset_checks("rst");
    @(negedge txclk);
    reset = 1'b1;
    repeat (2) @(negedge txclk);

    // all requesters held: grants 0,1,2,3,0
    en = 1'b1;
    bus.req_data = {9'h034, 9'h1E3, 9'h0F2, 9'h101};
    push(3'd0, 9'h101);
    push(3'd1, 9'h0F2);
    push(3'd2, 9'h1E3);
    push(3'd3, 9'h034);
    push(3'd0, 9'h101);
    last_rise = -1;
    gap_chk   = 1'b1;
    n0        = n_ld;
    bus.req   = 4'b1111;
    #1 check("tx_enable_on", tx_enable, 1'b1);
    wait_ld(n0 + 5, "rr_wait");
    bus.req = '0;
    gap_chk = 1'b0;
    wait_idle("rr_idle");

    // single requester 2, latency from IDLE
    @(negedge txclk);
    bus.req_data = {9'h000, 9'h1A5, 9'h000, 9'h000};
    push(3'd2, 9'h1A5);
    n0      = n_ld;
    req_cyc = cyc;
    bus.req = 4'b0100;
    wait_ld(n0 + 1, "single_wait");
    check("single_latency", 32'(ld_cyc - req_cyc), 1);
    bus.req = '0;
    wait_idle("single_idle");

    // en low blocks the grant, raising it loads next cycle
    @(negedge txclk);
    en = 1'b0;
    bus.req_data = {9'h000, 9'h000, 9'h0B7, 9'h000};
    push(3'd1, 9'h0B7);
    n0      = n_ld;
    bus.req = 4'b0010;
    #1 check("tx_enable_off", tx_enable, 1'b0);
    repeat (6) @(negedge txclk);
    check("en0_no_ld", 32'(n_ld), 32'(n0));
    check("en0_busy", busy, 1'b0);
    en      = 1'b1;
    req_cyc = cyc;
    wait_ld(n0 + 1, "en_wait");
    check("en_latency", 32'(ld_cyc - req_cyc), 1);
    bus.req = '0;
    wait_idle("en_idle");

    // transmitter never drains
    @(negedge txclk);
    tx_stuck = 1'b1;
    bus.req_data = {9'h155, 9'h000, 9'h000, 9'h000};
    push(3'd3, 9'h155);
    n0      = n_ld;
    bus.req = 4'b1000;
    wait_ld(n0 + 1, "stuck_wait");
    bus.req = '0;
    err_clr = 1'b1;
`ifdef UART9_TX_ARB_TIMEOUT_EN
    begin
      int k = 0;
      while (!err_timeout && k < 400) begin
        @(negedge txclk);
        k++;
      end
    end
    check("to_seen", err_timeout, 1'b1);
    check("to_latency", 32'(cyc - ld_cyc), TMO + 1);
    check("to_idle", busy, 1'b0);
    @(negedge txclk);
    check("to_cleared", err_timeout, 1'b0);
    err_clr  = 1'b0;
    tx_stuck = 1'b0;
    repeat (10) @(negedge txclk);
`else
    repeat (300) @(negedge txclk);
    check("stuck_busy", busy, 1'b1);
    check("stuck_no_err", err_timeout, 1'b0);
    err_clr  = 1'b0;
    tx_stuck = 1'b0;
    wait_idle("stuck_idle");
`endif

    // reset while DONE, then requester 0 wins first
    @(negedge txclk);
    tx_hold = 20;
    bus.req_data = {9'h000, 9'h0AA, 9'h000, 9'h1F0};
    push(3'd2, 9'h0AA);
    n0      = n_ld;
    bus.req = 4'b0100;
    wait_ld(n0 + 1, "done_wait");
    bus.req = '0;
    repeat (4) @(negedge txclk);
    check("done_busy", busy, 1'b1);
    @(posedge txclk);
    #3 reset = 1'b0;
    #1 reset_checks("async_rst");
    sb_q.delete();
    tx_hold = 3;
    repeat (3) @(negedge txclk);
    reset = 1'b1;
    n0    = n_ld;
    repeat (5) @(negedge txclk);
    check("post_rst_no_ld", 32'(n_ld), 32'(n0));
    push(3'd0, 9'h1F0);
    bus.req = 4'b1111;
    wait_ld(n0 + 1, "post_rst_wait");
    bus.req = '0;
    wait_idle("post_rst_idle");
    check("sb_empty", 32'(sb_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart9_tx_arbiter.md
UART9_TX_ARBITER -- requirements
Module: uart9_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters (2..8); SHALL size all per-requester buses.
REQ-002 Parameter GAP_CYCLES, default 2, idle txclk cycles inserted between frames (0 = none).
REQ-003 Parameter TIMEOUT_CYCLES, default 255, watchdog limit in txclk cycles per wait state.
REQ-004 One clock, txclk; reset is asynchronous and active-low, named reset.
REQ-005 txclk  input  1  sole clock, all state on rising edge.
REQ-006 reset  input  1  asynchronous active-low reset.
REQ-007 en  input  1  global enable; SHALL be forwarded to tx_enable.
REQ-008 req  input  N_REQ  per-requester level request, held until its ack.
REQ-009 req_data  input  9*N_REQ  requester i word at bits [9i+8:9i], stable while req[i]=1.
REQ-010 ack  output  N_REQ  one-cycle pulse, word of requester i accepted.
REQ-011 busy  output  1  high in any state except IDLE.
REQ-012 cur_id  output  3  index of last granted requester.
REQ-013 err_timeout  output  1  sticky watchdog flag.
REQ-014 err_clr  input  1  clears err_timeout.
REQ-015 ld_tx_data, tx_data[8:0], tx_enable  output  to the UART transmitter; tx_empty  input  1  from it.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, START, DONE, GAP.
REQ-017 IDLE: if en=1 and any req bit high, the winner SHALL be chosen round-robin starting at cur_id+1 (mod N_REQ); next state LOAD.
REQ-018 On the IDLE->LOAD edge, tx_data and cur_id SHALL register the winner's word/index.
REQ-019 LOAD (exactly one cycle): ld_tx_data=1 and ack[cur_id]=1, all other ack bits 0; next state START.
REQ-020 START: wait for tx_empty=0, then DONE; DONE: wait for tx_empty=1, then GAP (or IDLE if GAP_CYCLES=0).
REQ-021 GAP SHALL last exactly GAP_CYCLES cycles, then IDLE.
REQ-022 Requests arriving or dropping outside IDLE SHALL be ignored until next IDLE evaluation; at most one ack per frame.
REQ-023 tx_enable SHALL equal en combinationally; en=0 in IDLE blocks new grants; en=0 mid-frame SHALL NOT change state.
REQ-024 Request-to-ld_tx_data latency SHALL be 1 cycle from IDLE.
REQ-025 err_clr and a new timeout in the same cycle: set SHALL win.

Reset
REQ-026 On reset low: state IDLE, ld_tx_data=0, ack=0, tx_data=0, cur_id=N_REQ-1 (so requester 0 wins first), busy=0, err_timeout=0, counters 0.
REQ-027 Reset mid-frame SHALL abort immediately with no ack issued after release until a fresh IDLE grant.

Configuration
REQ-028 Macro UART9_TX_ARB_TIMEOUT_EN defined: a counter SHALL run in START and DONE; reaching TIMEOUT_CYCLES SHALL set err_timeout and force IDLE.
REQ-029 Macro undefined: no counter is built, START/DONE wait indefinitely, err_timeout tied 0, err_clr ignored.

Structure
REQ-030 Shared package uart9_pkg SHALL hold the FSM state encoding constants and the 9-bit word width constant.
REQ-031 Round-robin winner selection SHALL be a sub-module uart9_rr_pick (req vector + last index -> grant index + valid), combinational.

Verification
REQ-032 Single req[2]=1, data 0x1A5, TX model drops tx_empty 1 cycle after load -> ld_tx_data one pulse, tx_data=0x1A5, ack[2] pulse, cur_id=2.
REQ-033 All four req held -> grant order 0,1,2,3,0 with GAP_CYCLES=2 idle cycles between DONE exit and next LOAD.
REQ-034 en=0 with req[1]=1 -> no ld_tx_data; raise en -> LOAD next cycle.
REQ-035 TIMEOUT_EN defined, TX model never drops tx_empty -> err_timeout=1 after 255 cycles in START, state IDLE; err_clr clears it.
REQ-036 Reset asserted in DONE -> all outputs at reset values asynchronously; after release req[0] granted first.
